alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Upstream feeder and downstream capture stage for the combinational ALU.
- Accepts operation commands {opcode, in1, in2, tag} over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle from registered operand outputs that drive the ALU directly.
- Registers the ALU's 2*DATASIZE result, with its tag, into an output slot that has its own valid/ready handshake, so the combinational ALU sits between two clocked stages.

Parameters:
DATASIZE, 8, operand width of in1/in2.
OUTPUTSIZE, 2*DATASIZE, ALU result width.
OPCODE_WIDTH, 4, opcode width; the opcode is passed to the ALU uninterpreted.
TAG_WIDTH, 4, user tag carried alongside each command.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of FIFO, issue and result stages.
in_valid  in  1  command present.
in_ready  out  1  FIFO can accept a command.
in_opcode  in  OPCODE_WIDTH  command opcode.
in_a  in  DATASIZE  operand 1.
in_b  in  DATASIZE  operand 2.
in_tag  in  TAG_WIDTH  command tag.
alu_in1  out  DATASIZE  registered operand 1 to the ALU.
alu_in2  out  DATASIZE  registered operand 2 to the ALU.
alu_opcode  out  OPCODE_WIDTH  registered opcode to the ALU.
alu_result  in  OUTPUTSIZE  combinational result from the ALU.
res_valid  out  1  result slot holds data.
res_ready  in  1  consumer accepts the result.
res_data  out  OUTPUTSIZE  captured ALU result.
res_tag  out  TAG_WIDTH  tag of the captured result.
count  out  $clog2(DEPTH)+1  FIFO occupancy.
busy  out  1  high while FIFO non-empty, issue_valid, or res_valid.

Behaviour:
Reset:
- Asynchronous; reset is active-high, clock is clk.
- Clears rd/wr pointers, count, the internal issue_valid bit, res_valid, alu_in1/in2/opcode, res_data and res_tag, all to 0.
- in_ready comes out of reset at 1.
- Reset asserted mid-operation drops all queued and in-flight commands; no result is emitted for them.

FIFO:
- push = in_valid && in_ready.
- in_ready = (count != DEPTH). There is no pass-through when full, even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.
- count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.

Stage advance rules:
- res_free = !res_valid || res_ready.
- issue_adv = !issue_valid || res_free.
- pop = issue_adv && (count != 0).
- On pop: load the head entry into alu_in1/alu_in2/alu_opcode and an internal issue tag; set issue_valid = 1.
- On issue_adv without pop: clear issue_valid; the alu_* outputs hold their last values.

Capture:
- When issue_valid && res_free: load res_data <= alu_result and res_tag <= issue tag; set res_valid = 1.
- Otherwise, if res_ready: clear res_valid.
- res_data and res_tag are stable while res_valid && !res_ready.

Latency and throughput:
- A command accepted at edge N with an empty pipe gives alu_* valid after edge N+1 and res_valid after edge N+2.
- Throughput is 1 command/cycle with res_ready held high.
- Commands complete strictly in order.

Backpressure:
- With res_ready low, the result slot holds and the issue stage holds (alu_* stable).
- The FIFO fills to DEPTH, then in_ready drops.
- Maximum commands buffered = DEPTH + 2.

Flush:
- Synchronous and takes priority over all other activity in the same cycle.
- Next state: count = 0, issue_valid = 0, res_valid = 0, pointers = 0. A push in the same cycle is discarded.

busy is combinational from the state bits. count is registered.

Test Plan:
1. Reset, then a single command {opcode=0, in_a=8'h0F, in_b=8'h03, tag=1} -> alu_in1=8'h0F and alu_in2=8'h03 one cycle after accept; res_valid two cycles after accept; res_data equals the ALU's result for that triple; res_tag=1; busy returns to 0 after the result is consumed.
2. Eight back-to-back commands with tags 0..7 and res_ready=1 -> one result per cycle, tags in order 0..7; count never exceeds 1.
3. res_ready=0 while pushing 8 commands -> in_ready falls after 6 accepts (DEPTH + 2), count=4; alu_* and res_data stable; releasing res_ready drains tags in order with no loss or duplication.
4. FIFO full with a pop in the same cycle as in_valid=1 -> no accept that cycle; accept on the next cycle; count returns to 4.
5. flush asserted with 3 entries queued and res_valid=1 -> next cycle count=0, res_valid=0, busy=0, in_ready=1; the flushed tags never appear on res_tag.
6. rst pulsed asynchronously between clock edges with the pipe full -> all outputs zero immediately; a new command after rst drops completes normally with 2-cycle latency.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO, registered issue stage and result capture
// slot wrapped around an external combinational ALU.
module alu_issue_queue #(
    parameter int DATASIZE     = 8,
    parameter int OUTPUTSIZE   = 2 * DATASIZE,
    parameter int OPCODE_WIDTH = 4,
    parameter int TAG_WIDTH    = 4,
    parameter int DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   in_opcode,
    input  logic [DATASIZE-1:0]       in_a,
    input  logic [DATASIZE-1:0]       in_b,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic [DATASIZE-1:0]       alu_in1,
    output logic [DATASIZE-1:0]       alu_in2,
    output logic [OPCODE_WIDTH-1:0]   alu_opcode,
    input  logic [OUTPUTSIZE-1:0]     alu_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [OUTPUTSIZE-1:0]     res_data,
    output logic [TAG_WIDTH-1:0]      res_tag,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [DATASIZE-1:0]     a;
        logic [DATASIZE-1:0]     b;
        logic [TAG_WIDTH-1:0]    tag;
    } cmd_t;

    cmd_t                    mem_q [DEPTH];
    cmd_t                    mem_d [DEPTH];
    cmd_t                    head;

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    issue_valid_q, issue_valid_d;
    logic [TAG_WIDTH-1:0]    issue_tag_q, issue_tag_d;
    logic [DATASIZE-1:0]     alu_in1_q, alu_in1_d;
    logic [DATASIZE-1:0]     alu_in2_q, alu_in2_d;
    logic [OPCODE_WIDTH-1:0] alu_opcode_q, alu_opcode_d;

    logic                    res_valid_q, res_valid_d;
    logic [OUTPUTSIZE-1:0]   res_data_q, res_data_d;
    logic [TAG_WIDTH-1:0]    res_tag_q, res_tag_d;

    logic                    push, pop, res_free, issue_adv, capture;

    // Handshake and stage-advance terms; a full FIFO refuses pushes even
    // when the head is leaving in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign res_free  = !res_valid_q || res_ready;
    assign issue_adv = !issue_valid_q || res_free;
    assign pop       = issue_adv && (count_q != '0);
    assign capture   = issue_valid_q && res_free;
    assign head      = mem_q[rd_ptr_q];

    // Write the incoming command into the tail slot; flush discards it.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and start from a full default, so no latch can be inferred.
        mem_d = mem_q;
        if (push && !flush) begin
            mem_d[wr_ptr_q] = {in_opcode, in_a, in_b, in_tag};
        end
    end

    // Storage array register.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers and count alone decide which entries are live.
        mem_q <= mem_d;
    end

    // Pointer and occupancy next state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Issue stage: load the FIFO head, or drop valid when advancing empty-handed.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_tag_d   = issue_tag_q;
        alu_in1_d     = alu_in1_q;
        alu_in2_d     = alu_in2_q;
        alu_opcode_d  = alu_opcode_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (pop) begin
            issue_valid_d = 1'b1;
            issue_tag_d   = head.tag;
            alu_in1_d     = head.a;
            alu_in2_d     = head.b;
            alu_opcode_d  = head.opcode;
        end else if (issue_adv) begin
            issue_valid_d = 1'b0;
        end
    end

    // Result slot: capture the ALU output when free, else retire on res_ready.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_result;
            res_tag_d   = issue_tag_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Control and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_tag_q   <= '0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_opcode_q  <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_tag_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_tag_q   <= issue_tag_d;
            alu_in1_q     <= alu_in1_d;
            alu_in2_q     <= alu_in2_d;
            alu_opcode_q  <= alu_opcode_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_tag_q     <= res_tag_d;
        end
    end

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_opcode = alu_opcode_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;
    assign count      = count_q;
    assign busy       = (count_q != '0) || issue_valid_q || res_valid_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed testbench for alu_issue_queue with a stand-in combinational ALU.
module tb_alu_issue_queue;

    localparam int DW    = 8;
    localparam int OW    = 16;
    localparam int OPW   = 4;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_opcode;
    logic [DW-1:0]  in_a, in_b;
    logic [TW-1:0]  in_tag;
    logic [DW-1:0]  alu_in1, alu_in2;
    logic [OPW-1:0] alu_opcode;
    logic [OW-1:0]  alu_result;
    logic           res_valid;
    logic           res_ready;
    logic [OW-1:0]  res_data;
    logic [TW-1:0]  res_tag;
    logic [2:0]     count;
    logic           busy;

    int total = 0;
    int bad   = 0;

    alu_issue_queue #(
        .DATASIZE(DW), .OUTPUTSIZE(OW), .OPCODE_WIDTH(OPW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: add, multiply, concatenate, swapped concatenate.
    function automatic logic [OW-1:0] alu_f(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} * {8'h00, b};
            4'd2:    return {a, b};
            default: return {b, a};
        endcase
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_in1, alu_in2);

    // Command fields derived from the tag so expected results are self-contained.
    function automatic logic [DW-1:0]  a_of(input int t);  return DW'(t * 17); endfunction
    function automatic logic [DW-1:0]  b_of(input int t);  return DW'(t + 3);  endfunction
    function automatic logic [OPW-1:0] op_of(input int t); return OPW'(t % 3); endfunction
    function automatic logic [OW-1:0]  exp_data(input int t);
        return alu_f(op_of(t), a_of(t), b_of(t));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input int t);
        in_valid  = v;
        in_tag    = TW'(t);
        in_opcode = op_of(t);
        in_a      = a_of(t);
        in_b      = b_of(t);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
        drive_cmd(1'b0, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (alu_in1 !== 8'h00) begin bad++; $display("FAIL reset_alu_in1 got=%h exp=00", alu_in1); end
        total++; if (res_data !== 16'h0000) begin bad++; $display("FAIL reset_res_data got=%h exp=0000", res_data); end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        in_valid = 1'b1; in_opcode = 4'd0; in_a = 8'h0F; in_b = 8'h03; in_tag = 4'd1;
        step();
        in_valid = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count_after_accept got=%0d exp=1", count); end
        total++; if (alu_in1 !== 8'h00) begin bad++; $display("FAIL single_alu_early got=%h exp=00", alu_in1); end
        step();
        total++; if (alu_in1 !== 8'h0F) begin bad++; $display("FAIL single_alu_in1 got=%h exp=0f", alu_in1); end
        total++; if (alu_in2 !== 8'h03) begin bad++; $display("FAIL single_alu_in2 got=%h exp=03", alu_in2); end
        total++; if (alu_opcode !== 4'd0) begin bad++; $display("FAIL single_alu_opcode got=%0d exp=0", alu_opcode); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_res_early got=%0b exp=0", res_valid); end
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_res_valid got=%0b exp=1", res_valid); end
        total++; if (res_data !== 16'h0012) begin bad++; $display("FAIL single_res_data got=%h exp=0012", res_data); end
        total++; if (res_tag !== 4'd1) begin bad++; $display("FAIL single_res_tag got=%0d exp=1", res_tag); end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_res_retired got=%0b exp=0", res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (sent < 8) drive_cmd(1'b1, sent);
            else drive_cmd(1'b0, 0);
            if (in_valid && in_ready) sent++;
            total++; if (count > 3'd1) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp<=1", cyc, count); end
            if (res_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                total++; if (res_tag !== TW'(got)) begin bad++; $display("FAIL b2b_tag got=%0d exp=%0d", res_tag, got); end
                total++; if (res_data !== exp_data(got)) begin bad++; $display("FAIL b2b_data got=%h exp=%h", res_data, exp_data(got)); end
                got++;
            end
            step();
        end
        in_valid = 1'b0;
        total++; if (got != 8) begin bad++; $display("FAIL b2b_result_count got=%0d exp=8", got); end
        total++; if (last_cyc - first_cyc != 7) begin bad++; $display("FAIL b2b_throughput span got=%0d exp=7", last_cyc - first_cyc); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int expect_tag;
        logic [DW-1:0] s_in1, s_in2;
        logic [OW-1:0] s_data;
        res_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive_cmd(1'b1, accepted);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        total++; if (accepted != 6) begin bad++; $display("FAIL bp_accepts got=%0d exp=6", accepted); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        total++; if (res_tag !== 4'd0) begin bad++; $display("FAIL bp_res_tag got=%0d exp=0", res_tag); end
        total++; if (alu_in1 !== a_of(1)) begin bad++; $display("FAIL bp_alu_in1 got=%h exp=%h", alu_in1, a_of(1)); end
        s_in1 = alu_in1; s_in2 = alu_in2; s_data = res_data;
        repeat (3) step();
        total++; if (alu_in1 !== s_in1 || alu_in2 !== s_in2) begin bad++; $display("FAIL bp_alu_stable got=%h/%h exp=%h/%h", alu_in1, alu_in2, s_in1, s_in2); end
        total++; if (res_data !== s_data) begin bad++; $display("FAIL bp_res_stable got=%h exp=%h", res_data, s_data); end

        // Full FIFO with a pop in the same cycle: no accept.
        drive_cmd(1'b1, 6);
        res_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_no_accept in_ready got=%0b exp=0", in_ready); end
        total++; if (res_tag !== 4'd0) begin bad++; $display("FAIL full_pop_res_tag got=%0d exp=0", res_tag); end
        step();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_in_ready got=%0b exp=1", in_ready); end
        res_ready = 1'b0;
        step();
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL refill_count got=%0d exp=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL refill_in_ready got=%0b exp=0", in_ready); end

        res_ready = 1'b1;
        expect_tag = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (res_valid) begin
                total++; if (res_tag !== TW'(expect_tag)) begin bad++; $display("FAIL drain_tag got=%0d exp=%0d", res_tag, expect_tag); end
                total++; if (res_data !== exp_data(expect_tag)) begin bad++; $display("FAIL drain_data got=%h exp=%h", res_data, exp_data(expect_tag)); end
                expect_tag++;
            end
            step();
        end
        total++; if (expect_tag != 7) begin bad++; $display("FAIL drain_total got=%0d exp=7", expect_tag); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_flush();
        int seen_new = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(1'b1, i);
            step();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_res_valid got=%0b exp=1", res_valid); end
        flush = 1'b1;
        drive_cmd(1'b1, 9);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL flush_res_valid got=%0b exp=0", res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost cyc=%0d tag=%0d exp_valid=0", cyc, res_tag); end
            step();
        end
        drive_cmd(1'b1, 10);
        step();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (res_valid) begin
                seen_new++;
                total++; if (res_tag !== 4'd10) begin bad++; $display("FAIL flush_new_tag got=%0d exp=10", res_tag); end
            end
            step();
        end
        total++; if (seen_new != 1) begin bad++; $display("FAIL flush_new_results got=%0d exp=1", seen_new); end
    endtask

    task automatic test_async_reset();
        int accepted = 0;
        res_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive_cmd(1'b1, accepted);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%0b exp=1", busy); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL arst_res_valid got=%0b exp=0", res_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%0b exp=1", in_ready); end
        total++; if (alu_in1 !== 8'h00 || alu_in2 !== 8'h00 || alu_opcode !== 4'd0) begin bad++; $display("FAIL arst_alu got=%h/%h/%h exp=0/0/0", alu_in1, alu_in2, alu_opcode); end
        total++; if (res_data !== 16'h0000 || res_tag !== 4'd0) begin bad++; $display("FAIL arst_res got=%h/%0d exp=0/0", res_data, res_tag); end
        #2 rst = 1'b0;
        step();
        res_ready = 1'b1;
        drive_cmd(1'b1, 5);
        step();
        in_valid = 1'b0;
        total++; if (alu_in1 !== 8'h00) begin bad++; $display("FAIL arst_new_early got=%h exp=00", alu_in1); end
        step();
        total++; if (alu_in1 !== a_of(5)) begin bad++; $display("FAIL arst_new_alu_in1 got=%h exp=%h", alu_in1, a_of(5)); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL arst_new_res_early got=%0b exp=0", res_valid); end
        step();
        total++; if (res_valid !== 1'b1 || res_tag !== 4'd5) begin bad++; $display("FAIL arst_new_res got=%0b/%0d exp=1/5", res_valid, res_tag); end
        total++; if (res_data !== exp_data(5)) begin bad++; $display("FAIL arst_new_data got=%h exp=%h", res_data, exp_data(5)); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_new_busy got=%0b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
